// File: rtl/qpsk_prbs_checker_if.sv
// Receive-sample and result bundle between the QPSK receive chain and the PRBS9 checker.
interface qpsk_prbs_checker_if #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic                         en;
    logic                         clr;
    logic signed [DATA_WIDTH-1:0] rx_i;
    logic signed [DATA_WIDTH-1:0] rx_q;
    logic                         lock_i;
    logic                         lock_q;
    logic [CNT_WIDTH-1:0]         err_cnt_i;
    logic [CNT_WIDTH-1:0]         err_cnt_q;
    logic [CNT_WIDTH-1:0]         sym_cnt;

    modport master (
        output en, clr, rx_i, rx_q,
        input  lock_i, lock_q, err_cnt_i, err_cnt_q, sym_cnt
    );

    modport slave (
        input  en, clr, rx_i, rx_q,
        output lock_i, lock_q, err_cnt_i, err_cnt_q, sym_cnt
    );
endinterface

// File: rtl/qpsk_prbs_checker.sv
// QPSK PRBS9 (x^9 + x^5 + 1) receive checker: hard slicer, independent
// self-synchronising checker per branch, and saturating BER counters.
module qpsk_prbs_checker #(
    parameter int unsigned DATA_WIDTH  = 20,
    parameter int unsigned LOCK_LEN    = 32,
    parameter int unsigned WINDOW      = 128,
    parameter int unsigned LOSS_THRESH = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    qpsk_prbs_checker_if.slave chk_if
);

    localparam int unsigned NB      = 2;                        // branch 0 = I, 1 = Q
    localparam int unsigned HW      = 9;                        // PRBS9 history length
    localparam int unsigned FILL_W  = 4;
    localparam int unsigned MATCH_W = $clog2(LOCK_LEN + 1);
    localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 2);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q   [NB];
    state_e             state_d   [NB];
    logic [HW-1:0]      hist_q    [NB];
    logic [HW-1:0]      hist_d    [NB];
    logic [FILL_W-1:0]  fill_q    [NB];
    logic [FILL_W-1:0]  fill_d    [NB];
    logic [MATCH_W-1:0] match_q   [NB];
    logic [MATCH_W-1:0] match_d   [NB];
    logic [WIN_W-1:0]   win_cnt_q [NB];
    logic [WIN_W-1:0]   win_cnt_d [NB];
    logic [WERR_W-1:0]  win_err_q [NB];
    logic [WERR_W-1:0]  win_err_d [NB];
    logic [WERR_W-1:0]  werr_inc  [NB];
    logic               locked_q  [NB];
    logic               locked_d  [NB];

    logic               rx_bit    [NB];
    logic               pred      [NB];
    logic               mism      [NB];

    logic [CNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_WIDTH-1:0] err_i_q,   err_i_d;
    logic [CNT_WIDTH-1:0] err_q_q,   err_q_d;
    logic                 count_en;

    // Slicer (negative -> 1) and per-branch prediction b[n] = b[n-9] ^ b[n-5].
    always_comb begin
        rx_bit[0] = ($signed(chk_if.rx_i) < $signed(DATA_WIDTH'(0)));
        rx_bit[1] = ($signed(chk_if.rx_q) < $signed(DATA_WIDTH'(0)));
        for (int b = 0; b < NB; b++) begin
            pred[b] = hist_q[b][8] ^ hist_q[b][4];
            mism[b] = pred[b] ^ rx_bit[b];
        end
    end

    // Per-branch FILL/SEARCH/LOCKED next-state and datapath.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            state_d[b]   = state_q[b];
            hist_d[b]    = hist_q[b];
            fill_d[b]    = fill_q[b];
            match_d[b]   = match_q[b];
            win_cnt_d[b] = win_cnt_q[b];
            win_err_d[b] = win_err_q[b];
            werr_inc[b]  = win_err_q[b] + WERR_W'(mism[b]);

            if (chk_if.en) begin
                unique case (state_q[b])
                    ST_FILL: begin
                        hist_d[b] = {hist_q[b][HW-2:0], rx_bit[b]};
                        if (fill_q[b] == FILL_W'(HW - 1)) begin
                            state_d[b] = ST_SEARCH;
                            fill_d[b]  = '0;
                            match_d[b] = '0;
                        end else begin
                            fill_d[b] = fill_q[b] + FILL_W'(1);
                        end
                    end
                    ST_SEARCH: begin
                        hist_d[b] = {hist_q[b][HW-2:0], rx_bit[b]};
                        if (mism[b]) begin
                            match_d[b] = '0;
                        end else if (match_q[b] == MATCH_W'(LOCK_LEN - 1)) begin
                            state_d[b]   = ST_LOCKED;
                            match_d[b]   = '0;
                            win_cnt_d[b] = '0;
                            win_err_d[b] = '0;
                        end else begin
                            match_d[b] = match_q[b] + MATCH_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run on the prediction so line errors do not propagate.
                        hist_d[b] = {hist_q[b][HW-2:0], pred[b]};
                        if (mism[b] && (werr_inc[b] > WERR_W'(LOSS_THRESH))) begin
                            state_d[b] = ST_FILL;
                            fill_d[b]  = '0;
                        end else if (win_cnt_q[b] == WIN_W'(WINDOW - 1)) begin
                            win_cnt_d[b] = '0;
                            win_err_d[b] = '0;
                        end else begin
                            win_cnt_d[b] = win_cnt_q[b] + WIN_W'(1);
                            win_err_d[b] = werr_inc[b];
                        end
                    end
                    default: begin
                        state_d[b] = ST_FILL;
                        fill_d[b]  = '0;
                    end
                endcase
            end

            locked_d[b] = (state_d[b] == ST_LOCKED);
        end
    end

    // Per-branch state, history and lock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) begin
                state_q[b]   <= ST_FILL;
                hist_q[b]    <= '0;
                fill_q[b]    <= '0;
                match_q[b]   <= '0;
                win_cnt_q[b] <= '0;
                win_err_q[b] <= '0;
                locked_q[b]  <= 1'b0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                state_q[b]   <= state_d[b];
                hist_q[b]    <= hist_d[b];
                fill_q[b]    <= fill_d[b];
                match_q[b]   <= match_d[b];
                win_cnt_q[b] <= win_cnt_d[b];
                win_err_q[b] <= win_err_d[b];
                locked_q[b]  <= locked_d[b];
            end
        end
    end

    // Saturating BER counters; active only while both branches were locked, clr wins.
    always_comb begin
        count_en  = chk_if.en && locked_q[0] && locked_q[1];
        sym_cnt_d = sym_cnt_q;
        err_i_d   = err_i_q;
        err_q_d   = err_q_q;
        if (chk_if.clr) begin
            sym_cnt_d = '0;
            err_i_d   = '0;
            err_q_d   = '0;
        end else if (count_en) begin
            if (sym_cnt_q != '1)           sym_cnt_d = sym_cnt_q + CNT_WIDTH'(1);
            if (mism[0] && err_i_q != '1)  err_i_d   = err_i_q + CNT_WIDTH'(1);
            if (mism[1] && err_q_q != '1)  err_q_d   = err_q_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q <= '0;
            err_i_q   <= '0;
            err_q_q   <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            err_i_q   <= err_i_d;
            err_q_q   <= err_q_d;
        end
    end

    assign chk_if.lock_i    = locked_q[0];
    assign chk_if.lock_q    = locked_q[1];
    assign chk_if.err_cnt_i = err_i_q;
    assign chk_if.err_cnt_q = err_q_q;
    assign chk_if.sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_qpsk_prbs_checker.sv
// Randomised bench for qpsk_prbs_checker: PRBS9 source with error injection,
// behavioural lock/BER model, one 32-bit and one 4-bit counter instance.
module tb_qpsk_prbs_checker;

    localparam int DW          = 20;
    localparam int LOCK_LEN    = 32;
    localparam int WINDOW      = 128;
    localparam int LOSS_THRESH = 16;
    localparam int M_FILL      = 0;
    localparam int M_SEARCH    = 1;
    localparam int M_LOCKED    = 2;

    logic clk;
    logic rst_n;

    qpsk_prbs_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) bus32 ();
    qpsk_prbs_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

    assign bus4.en   = bus32.en;
    assign bus4.clr  = bus32.clr;
    assign bus4.rx_i = bus32.rx_i;
    assign bus4.rx_q = bus32.rx_q;

    qpsk_prbs_checker #(
        .DATA_WIDTH(DW), .LOCK_LEN(LOCK_LEN), .WINDOW(WINDOW),
        .LOSS_THRESH(LOSS_THRESH), .CNT_WIDTH(32)
    ) u_dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .chk_if (bus32)
    );

    qpsk_prbs_checker #(
        .DATA_WIDTH(DW), .LOCK_LEN(LOCK_LEN), .WINDOW(WINDOW),
        .LOSS_THRESH(LOSS_THRESH), .CNT_WIDTH(4)
    ) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .chk_if (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transmit-side PRBS9 generators.
    logic [8:0] tx_st [2];

    // Reference model: reconstructed sequence per branch plus lock bookkeeping.
    bit     ref_seq [2][0:8191];
    int     ref_len [2];
    int     mode    [2];
    int     streak  [2];
    int     lk_n    [2];
    int     lk_werr [2];
    longint m_sym   [2];
    longint m_ei    [2];
    longint m_eq    [2];
    longint cmax    [2];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit prbs_next(input int b);
        bit nb;
        nb = tx_st[b][8] ^ tx_st[b][4];
        tx_st[b] = {tx_st[b][7:0], nb};
        return nb;
    endfunction

    function automatic logic [DW-1:0] to_sample(input bit b);
        logic [DW-1:0] s;
        s = {b, (DW-1)'($urandom)};
        if (!b && $urandom_range(0, 7) == 0) s = '0;
        return s;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            ref_len[b] = 0;
            mode[b]    = M_FILL;
            streak[b]  = 0;
            lk_n[b]    = 0;
            lk_werr[b] = 0;
        end
        for (int w = 0; w < 2; w++) begin
            m_sym[w] = 0;
            m_ei[w]  = 0;
            m_eq[w]  = 0;
        end
    endtask

    // One received bit on one branch; returns whether it disagreed with the sequence rule.
    function automatic bit model_branch(input int b, input bit rx);
        bit pr;
        bit mis;
        mis = 1'b0;
        if (mode[b] == M_FILL) begin
            ref_seq[b][ref_len[b]] = rx;
            ref_len[b]++;
            if (ref_len[b] == 9) begin
                mode[b]   = M_SEARCH;
                streak[b] = 0;
            end
        end else begin
            pr  = ref_seq[b][ref_len[b] - 9] ^ ref_seq[b][ref_len[b] - 5];
            mis = (pr != rx);
            if (mode[b] == M_SEARCH) begin
                streak[b] = mis ? 0 : streak[b] + 1;
                ref_seq[b][ref_len[b]] = rx;
                ref_len[b]++;
                if (streak[b] == LOCK_LEN) begin
                    mode[b]    = M_LOCKED;
                    lk_n[b]    = 0;
                    lk_werr[b] = 0;
                end
            end else begin
                if (lk_n[b] % WINDOW == 0) lk_werr[b] = 0;
                if (mis) lk_werr[b]++;
                ref_seq[b][ref_len[b]] = pr;
                ref_len[b]++;
                lk_n[b]++;
                if (lk_werr[b] > LOSS_THRESH) begin
                    mode[b]    = M_FILL;
                    ref_len[b] = 0;
                end
            end
        end
        return mis;
    endfunction

    task automatic model_step(input bit e, input bit c, input bit bi, input bit bq);
        bit both;
        bit mi;
        bit mq;
        both = (mode[0] == M_LOCKED) && (mode[1] == M_LOCKED);
        mi = 1'b0;
        mq = 1'b0;
        if (e) begin
            mi = model_branch(0, bi);
            mq = model_branch(1, bq);
        end
        for (int w = 0; w < 2; w++) begin
            if (c) begin
                m_sym[w] = 0;
                m_ei[w]  = 0;
                m_eq[w]  = 0;
            end else if (e && both) begin
                if (m_sym[w] < cmax[w])       m_sym[w]++;
                if (mi && m_ei[w] < cmax[w])  m_ei[w]++;
                if (mq && m_eq[w] < cmax[w])  m_eq[w]++;
            end
        end
    endtask

    task automatic check_all();
        check("lock_i",       longint'(bus32.lock_i),    longint'(mode[0] == M_LOCKED));
        check("lock_q",       longint'(bus32.lock_q),    longint'(mode[1] == M_LOCKED));
        check("err_cnt_i",    longint'(bus32.err_cnt_i), m_ei[0]);
        check("err_cnt_q",    longint'(bus32.err_cnt_q), m_eq[0]);
        check("sym_cnt",      longint'(bus32.sym_cnt),   m_sym[0]);
        check("w4_lock_i",    longint'(bus4.lock_i),     longint'(mode[0] == M_LOCKED));
        check("w4_lock_q",    longint'(bus4.lock_q),     longint'(mode[1] == M_LOCKED));
        check("w4_err_cnt_i", longint'(bus4.err_cnt_i),  m_ei[1]);
        check("w4_err_cnt_q", longint'(bus4.err_cnt_q),  m_eq[1]);
        check("w4_sym_cnt",   longint'(bus4.sym_cnt),    m_sym[1]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_lock_i"},  longint'(bus32.lock_i),    0);
        check({tag, "_lock_q"},  longint'(bus32.lock_q),    0);
        check({tag, "_err_i"},   longint'(bus32.err_cnt_i), 0);
        check({tag, "_err_q"},   longint'(bus32.err_cnt_q), 0);
        check({tag, "_sym"},     longint'(bus32.sym_cnt),   0);
        check({tag, "_w4_err"},  longint'(bus4.err_cnt_i),  0);
        check({tag, "_w4_sym"},  longint'(bus4.sym_cnt),    0);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input bit e, input bit c, input bit fi, input bit fq);
        bit bi;
        bit bq;
        if (e) begin
            bi = prbs_next(0) ^ fi;
            bq = prbs_next(1) ^ fq;
        end else begin
            bi = 1'($urandom);
            bq = 1'($urandom);
        end
        bus32.en   = e;
        bus32.clr  = c;
        bus32.rx_i = to_sample(bi);
        bus32.rx_q = to_sample(bq);
        @(posedge clk);
        model_step(e, c, bi, bq);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset asserted between edges, released at a negedge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int n_en;
        int pct;
        cmax[0] = 64'hFFFF_FFFF;
        cmax[1] = 15;
        tx_st[0] = 9'($urandom_range(1, 511));
        tx_st[1] = 9'($urandom_range(1, 511));
        rst_n      = 1'b0;
        bus32.en   = 1'b0;
        bus32.clr  = 1'b0;
        bus32.rx_i = '0;
        bus32.rx_q = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Clean loopback from reset: lock after the 41st sample, sym_cnt = N - 41.
        for (int i = 0; i < 120; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 39) check("lock_i_at40", longint'(bus32.lock_i), 0);
            if (i == 40) begin
                check("lock_i_at41", longint'(bus32.lock_i), 1);
                check("lock_q_at41", longint'(bus32.lock_q), 1);
            end
        end
        check("sym_after_120", longint'(bus32.sym_cnt), 79);
        check("clean_err_i",   longint'(bus32.err_cnt_i), 0);

        // Single I error while locked.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("single_err_i", longint'(bus32.err_cnt_i), 1);
        check("single_err_q", longint'(bus32.err_cnt_q), 0);
        check("single_lock",  longint'(bus32.lock_i & bus32.lock_q), 1);

        // Asynchronous reset mid-lock, then reacquire.
        async_reset("arst1");
        for (int i = 0; i < 41; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 39) check("relock_at40", longint'(bus32.lock_i), 0);
            if (i == 40) check("relock_at41", longint'(bus32.lock_q), 1);
        end

        // Random en duty: lock exactly after 41 en-high samples.
        async_reset("arst2");
        n_en = 0;
        for (int i = 0; i < 200; i++) begin
            bit e;
            e = 1'($urandom);
            cycle(e, 1'b0, 1'b0, 1'b0);
            if (e) n_en++;
            check("lock_vs_en_count", longint'(bus32.lock_i), longint'(n_en >= 41));
        end

        // 17 consecutive I errors right after lock: drop on the 17th, relock 41 later.
        async_reset("arst3");
        repeat (41) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (17) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("burst_err_i",  longint'(bus32.err_cnt_i), 17);
        check("burst_lock_i", longint'(bus32.lock_i), 0);
        check("burst_lock_q", longint'(bus32.lock_q), 1);
        check("burst_sym",    longint'(bus32.sym_cnt), 17);
        repeat (40) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("burst_relock_40", longint'(bus32.lock_i), 0);
        check("burst_sym_frozen", longint'(bus32.sym_cnt), 17);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("burst_relock_41", longint'(bus32.lock_i), 1);

        // Isolated errors: 4-bit counter saturates; clr beats a coincident error.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            repeat (9) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("sat_w4_err_i", longint'(bus4.err_cnt_i), 15);
        check("sat_w32_err_i", longint'(bus32.err_cnt_i), 20);
        check("sat_lock_i",   longint'(bus32.lock_i), 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_w4_err_i",  longint'(bus4.err_cnt_i), 0);
        check("clr_w32_err_i", longint'(bus32.err_cnt_i), 0);

        // Random traffic at increasing error rates, with gaps and occasional clears.
        for (int seg = 0; seg < 3; seg++) begin
            pct = (seg == 0) ? 2 : (seg == 1) ? 10 : 30;
            for (int i = 0; i < 600; i++) begin
                cycle(1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 99) == 0),
                      1'($urandom_range(0, 99) < pct),
                      1'($urandom_range(0, 99) < pct / 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
